// File: rtl/seq_detector_param_pkg.sv
// Shared types for the programmable serial pattern detector.
// Holds the FSM state encoding and the fill-counter width helper.
package seq_detector_param_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_t;

  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Control/data bundle of seq_detector_param.
// master drives en/d/overlap/pat_load/pat_in/clr_cnt; slave drives results.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               d;
  logic               overlap;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               clr_cnt;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;
  logic               armed;

  modport master (
    output en, d, overlap, pat_load, pat_in, clr_cnt,
    input  match, match_cnt, cnt_sat, armed
  );

  modport slave (
    input  en, d, overlap, pat_load, pat_in, clr_cnt,
    output match, match_cnt, cnt_sat, armed
  );
endinterface

// File: rtl/seq_match_counter.sv
// Saturating match counter; clr wins but a same-cycle inc counts as one.
// Ports: clk, rst (async high), inc, clr -> cnt, sat (cnt is all-ones).
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (clr)
      cnt_n = inc ? CNT_W'(1) : '0;
    else if (inc && !(&cnt))
      cnt_n = cnt + CNT_W'(1);
  end

  // sat mirrors the saturated value, so it is sticky until clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_n;
      sat <= &cnt_n;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector, registered match pulse.
// Ports: clk, rst (async high), bus (slave): en/d/overlap/pat_* in, match/cnt/armed out.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 PAT_LEN     = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1001
) (
  input  logic                clk,
  input  logic                rst,
  seq_detector_param_if.slave bus
);

  localparam int FW = fill_w(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  det_state_t         state, state_n;
  logic [PAT_LEN-1:0] hist, hist_n, hist_sh;
  logic [PAT_LEN-1:0] pat, pat_n;
  logic [FW-1:0]      fill, fill_n, fill_inc;
  logic               hit;
  logic               match_q;

  assign hist_sh  = {hist[PAT_LEN-2:0], bus.d};
  assign fill_inc = (fill == FULL) ? fill : fill + FW'(1);

  // Pattern load beats en: the load-cycle bit is dropped.
  always_comb begin
    state_n = state;
    hist_n  = hist;
    pat_n   = pat;
    fill_n  = fill;
    hit     = 1'b0;
    if (bus.pat_load) begin
      pat_n   = bus.pat_in;
      fill_n  = '0;
      state_n = ST_FILL;
    end else if (bus.en) begin
      hist_n = hist_sh;
      fill_n = fill_inc;
      hit    = (fill_inc == FULL) && (hist_sh == pat);
      unique case (state)
        ST_FILL:  state_n = (fill_inc == FULL) ? ST_ARMED : ST_FILL;
        ST_ARMED: state_n = ST_ARMED;
      endcase
      // Non-overlapping: matched bits cannot seed the next match.
      if (hit && !bus.overlap) begin
        fill_n  = '0;
        state_n = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FILL;
      hist    <= '0;
      pat     <= DEFAULT_PAT;
      fill    <= '0;
      match_q <= 1'b0;
    end else begin
      state   <= state_n;
      hist    <= hist_n;
      pat     <= pat_n;
      fill    <= fill_n;
      match_q <= hit;
    end
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (bus.clr_cnt),
    .cnt (bus.match_cnt),
    .sat (bus.cnt_sat)
  );

  assign bus.match = match_q;
  assign bus.armed = (state == ST_ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: vector table, corner sequences, random vs model.
// Two instances: defaults (4-bit, 8-bit count) and a 2-bit pattern with 2-bit counter.
module tb_seq_detector_param;

  logic clk;
  logic rst;

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) b0 ();
  seq_detector_param_if #(.PAT_LEN(2), .CNT_W(2)) b1 ();

  seq_detector_param #(
    .PAT_LEN(4), .CNT_W(8), .DEFAULT_PAT(4'b1001)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  seq_detector_param #(
    .PAT_LEN(2), .CNT_W(2), .DEFAULT_PAT(2'b11)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: keep the bits seen since the last reset, pattern
  // load or non-overlapping hit; a hit is the newest 4 of them == pattern.
  bit         fresh[$];
  logic [3:0] m_pat;
  int         m_cnt;
  bit         m_match;

  task automatic model_reset();
    fresh.delete();
    m_pat   = 4'b1001;
    m_cnt   = 0;
    m_match = 0;
  endtask

  task automatic model_step(input logic e, dd, ov, ld,
                            input logic [3:0] pin, input logic clr);
    bit hit;
    hit = 0;
    if (ld) begin
      m_pat = pin;
      fresh.delete();
    end else if (e) begin
      fresh.push_back(dd);
      if (fresh.size() > 4) void'(fresh.pop_front());
      hit = (fresh.size() == 4) &&
            ({fresh[0], fresh[1], fresh[2], fresh[3]} == m_pat);
      if (hit && !ov) fresh.delete();
    end
    m_match = hit;
    if (clr) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < 255) m_cnt++;
  endtask

  task automatic apply(input logic e, dd, ov, ld,
                       input logic [3:0] pin, input logic clr);
    b0.en = e; b0.d = dd; b0.overlap = ov;
    b0.pat_load = ld; b0.pat_in = pin; b0.clr_cnt = clr;
    @(posedge clk);
    #1;
    model_step(e, dd, ov, ld, pin, clr);
    chk("model_match", 32'(b0.match), 32'(m_match));
    chk("model_cnt", 32'(b0.match_cnt), 32'(m_cnt));
    chk("model_sat", 32'(b0.cnt_sat), 32'(m_cnt == 255));
    chk("model_armed", 32'(b0.armed), 32'(fresh.size() == 4));
  endtask

  task automatic bit0(input logic dd, input logic ov);
    apply(1'b1, dd, ov, 1'b0, 4'b0000, 1'b0);
  endtask

  // Async reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_match", 32'(b0.match), 32'd0);
    chk("rst_cnt", 32'(b0.match_cnt), 32'd0);
    chk("rst_sat", 32'(b0.cnt_sat), 32'd0);
    chk("rst_armed", 32'(b0.armed), 32'd0);
    model_reset();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst_b;
    logic       d;
    logic       ov;
    logic       m;
    logic [7:0] cnt;
    logic       arm;
  } vec_t;

  vec_t tbl[14];
  int   hits;

  initial begin
    b0.en = 0; b0.d = 0; b0.overlap = 0;
    b0.pat_load = 0; b0.pat_in = '0; b0.clr_cnt = 0;
    b1.en = 0; b1.d = 0; b1.overlap = 1;
    b1.pat_load = 0; b1.pat_in = '0; b1.clr_cnt = 0;
    rst = 1'b1;
    model_reset();

    // Stream 1001001, overlap then non-overlap.
    tbl[0]  = '{1, 1, 1, 0, 8'd0, 0};
    tbl[1]  = '{0, 0, 1, 0, 8'd0, 0};
    tbl[2]  = '{0, 0, 1, 0, 8'd0, 0};
    tbl[3]  = '{0, 1, 1, 1, 8'd1, 1};
    tbl[4]  = '{0, 0, 1, 0, 8'd1, 1};
    tbl[5]  = '{0, 0, 1, 0, 8'd1, 1};
    tbl[6]  = '{0, 1, 1, 1, 8'd2, 1};
    tbl[7]  = '{1, 1, 0, 0, 8'd0, 0};
    tbl[8]  = '{0, 0, 0, 0, 8'd0, 0};
    tbl[9]  = '{0, 0, 0, 0, 8'd0, 0};
    tbl[10] = '{0, 1, 0, 1, 8'd1, 0};
    tbl[11] = '{0, 0, 0, 0, 8'd1, 0};
    tbl[12] = '{0, 0, 0, 0, 8'd1, 0};
    tbl[13] = '{0, 1, 0, 0, 8'd1, 0};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst_b) do_reset();
      bit0(tbl[i].d, tbl[i].ov);
      chk($sformatf("tbl%0d_match", i), 32'(b0.match), 32'(tbl[i].m));
      chk($sformatf("tbl%0d_cnt", i), 32'(b0.match_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_armed", i), 32'(b0.armed), 32'(tbl[i].arm));
    end

    // en gaps: 1,0,0,1 with three idle cycles between bits.
    do_reset();
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      bit0((i == 0 || i == 3), 1'b1);
      hits += int'(b0.match);
      if (i < 3)
        for (int k = 0; k < 3; k++) begin
          apply(1'b0, 1'($urandom_range(1)), 1'b1, 1'b0, 4'b0, 1'b0);
          hits += int'(b0.match);
        end
    end
    chk("gap_last_match", 32'(b0.match), 32'd1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    chk("gap_pulse_end", 32'(b0.match), 32'd0);
    chk("gap_hits", 32'(hits), 32'd1);

    // Pattern load mid-stream; the load-cycle d=1 must be ignored.
    do_reset();
    bit0(1, 1); bit0(0, 1); bit0(0, 1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0);
    chk("load_match", 32'(b0.match), 32'd0);
    chk("load_armed", 32'(b0.armed), 32'd0);
    bit0(1, 1); bit0(1, 1); bit0(1, 1);
    chk("load_3rd", 32'(b0.match), 32'd0);
    bit0(1, 1);
    chk("load_4th", 32'(b0.match), 32'd1);

    // Reset mid-stream after a custom load restores DEFAULT_PAT.
    do_reset();
    apply(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
    bit0(1, 1); bit0(0, 1); bit0(0, 1);
    do_reset();
    bit0(1, 1);
    chk("rst_mid_match", 32'(b0.match), 32'd0);
    chk("rst_mid_armed", 32'(b0.armed), 32'd0);
    chk("rst_mid_cnt", 32'(b0.match_cnt), 32'd0);
    bit0(0, 1); bit0(0, 1); bit0(1, 1);
    chk("rst_mid_default", 32'(b0.match), 32'd1);

    // 2-bit pattern 11, 2-bit counter: saturation then clr with hit.
    do_reset();
    b0.en = 0;
    b1.en = 1; b1.d = 1; b1.overlap = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_match", i), 32'(b1.match), 32'(i > 0));
      chk($sformatf("sat%0d_cnt", i), 32'(b1.match_cnt),
          32'(i > 3 ? 3 : i));
      chk($sformatf("sat%0d_sat", i), 32'(b1.cnt_sat), 32'(i >= 3));
    end
    b1.clr_cnt = 1;
    @(posedge clk);
    #1;
    chk("clrhit_match", 32'(b1.match), 32'd1);
    chk("clrhit_cnt", 32'(b1.match_cnt), 32'd1);
    chk("clrhit_sat", 32'(b1.cnt_sat), 32'd0);
    b1.clr_cnt = 0;
    b1.en = 0;

    // Randomised run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      apply(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(39) == 0),
            4'($urandom_range(15)), 1'($urandom_range(59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
